// File: rtl/instr_cache_fill_ctrl_pkg.sv
// ============================================================================
// Module : instr_cache_fill_ctrl_pkg
// Brief  : Shared types and helpers for the icache refill controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_cache_fill_ctrl_pkg;

    localparam int PADDR_WIDTH = 32;

    typedef logic [PADDR_WIDTH-1:0] paddr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_FILL = 2'd3
    } icache_fill_state_t;

    // Clears the byte-offset bits so the address points at the start of its line.
    function automatic paddr_t line_align(input paddr_t addr, input int unsigned offset_bits);
        paddr_t mask;
        mask = ~((paddr_t'(1) << offset_bits) - paddr_t'(1));
        return addr & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_cache_fill_ctrl.sv
// ============================================================================
// Module : instr_cache_fill_ctrl
// Brief  : Icache miss/refill controller: fetches a line beat by beat, writes
//          the data array, then issues a one-cycle tag-array fill.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_cache_fill_ctrl
    import instr_cache_fill_ctrl_pkg::*;
#(
    parameter int CACHELINE_SIZE      = 16,
    parameter int CACHELINE_SIZE_BITS = 4,
    parameter int NUM_ENTRIES_BITS    = 5,
    parameter int DATA_WIDTH          = 32,
    parameter int WORD_BITS           = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clear,
    input  logic                        i_miss,
    input  paddr_t                      i_miss_paddr,
    output logic                        o_busy,
    output logic                        o_mem_req,
    output paddr_t                      o_mem_paddr,
    input  logic                        i_mem_ack,
    input  logic                        i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]       i_mem_rdata,
    output logic                        o_data_we,
    output logic [NUM_ENTRIES_BITS-1:0] o_data_idx,
    output logic [WORD_BITS-1:0]        o_data_word,
    output logic [DATA_WIDTH-1:0]       o_data_wdata,
    output logic                        o_fill,
    output paddr_t                      o_fill_paddr,
    input  logic [31:0]                 i_log_fd
);

    icache_fill_state_t    r_state;
    icache_fill_state_t    w_state_nxt;
    paddr_t                r_line;
    logic [WORD_BITS-1:0]  r_word;
    logic                  r_squash;
    logic                  w_accept;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_unused_ok;

    assign w_accept    = (r_state == ST_IDLE) && i_miss && !i_clear;
    assign w_beat      = (r_state == ST_RESP) && i_mem_rvalid;
    assign w_last_beat = w_beat && (&r_word);

    assign o_data_idx  = r_line[CACHELINE_SIZE_BITS +: NUM_ENTRIES_BITS];
    assign o_data_word = r_word;

    // The log handle only matters to simulation-side tracing.
    assign w_unused_ok = &{1'b0, i_log_fd, CACHELINE_SIZE[0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_paddr  = '0;
        o_data_we    = 1'b0;
        o_data_wdata = '0;
        o_fill       = 1'b0;
        o_fill_paddr = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                o_busy      = 1'b1;
                o_mem_req   = 1'b1;
                o_mem_paddr = r_line;
                if (i_mem_ack) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                o_busy = 1'b1;
                if (i_mem_rvalid) begin
                    o_data_we    = 1'b1;
                    o_data_wdata = i_mem_rdata;
                end
                if (w_last_beat) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                o_busy = 1'b1;
                // A flush landing in the fill cycle itself also invalidates the line.
                if (!r_squash && !i_clear) begin
                    o_fill       = 1'b1;
                    o_fill_paddr = r_line;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line   <= '0;
            r_word   <= '0;
            r_squash <= 1'b0;
        end else if (w_accept) begin
            r_line   <= line_align(i_miss_paddr, CACHELINE_SIZE_BITS);
            r_word   <= '0;
            r_squash <= 1'b0;
        end else begin
            if ((r_state != ST_IDLE) && i_clear) begin
                r_squash <= 1'b1;
            end
            if (w_beat) begin
                r_word <= r_word + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_cache_fill_ctrl.sv
// ============================================================================
// Module : tb_instr_cache_fill_ctrl
// Brief  : Vector table, directed refill sequences and a randomized bus model
//          with a transaction-level reference for instr_cache_fill_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_cache_fill_ctrl;

    typedef struct {
        logic        miss, clear, ack, rvalid;
        logic [31:0] paddr, rdata;
        logic        e_busy, e_req;
        logic [31:0] e_mpaddr;
        logic        e_we;
        logic [4:0]  e_idx;
        logic [1:0]  e_word;
        logic [31:0] e_wdata;
        logic        e_fill;
        logic [31:0] e_fpaddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0, miss = 1'b0, mem_ack = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] miss_paddr = '0, mem_rdata = '0;
    logic        busy, mem_req, data_we, fill;
    logic [31:0] mem_paddr, fill_paddr, data_wdata;
    logic [4:0]  data_idx;
    logic [1:0]  data_word;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instr_cache_fill_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_miss(miss),
        .i_miss_paddr(miss_paddr), .o_busy(busy), .o_mem_req(mem_req),
        .o_mem_paddr(mem_paddr), .i_mem_ack(mem_ack), .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata(mem_rdata), .o_data_we(data_we), .o_data_idx(data_idx),
        .o_data_word(data_word), .o_data_wdata(data_wdata), .o_fill(fill),
        .o_fill_paddr(fill_paddr), .i_log_fd(32'h0)
    );

    function automatic vec_t mkv(
        input logic m, input logic c, input logic a, input logic rv,
        input logic [31:0] pa, input logic [31:0] rd,
        input logic eb, input logic er, input logic [31:0] emp,
        input logic ew, input logic [4:0] ei, input logic [1:0] ewd, input logic [31:0] edat,
        input logic ef, input logic [31:0] efp);
        vec_t v;
        v.miss = m; v.clear = c; v.ack = a; v.rvalid = rv; v.paddr = pa; v.rdata = rd;
        v.e_busy = eb; v.e_req = er; v.e_mpaddr = emp; v.e_we = ew; v.e_idx = ei;
        v.e_word = ewd; v.e_wdata = edat; v.e_fill = ef; v.e_fpaddr = efp;
        return v;
    endfunction

    function automatic logic [4:0] idx_of(input logic [31:0] a);
        return 5'((a >> 4) % 32);
    endfunction

    // Entered at posedge+1; drives the cycle, checks at the falling edge, leaves at posedge+1.
    task automatic apply_vec(input vec_t v, input string nm);
        logic [106:0] act, exp;
        miss = v.miss; clear = v.clear; mem_ack = v.ack; mem_rvalid = v.rvalid;
        miss_paddr = v.paddr; mem_rdata = v.rdata;
        @(negedge clk);
        act = {busy, mem_req, v.e_req ? mem_paddr : 32'h0, data_we,
               v.e_we ? data_idx : 5'h0, v.e_we ? data_word : 2'h0,
               v.e_we ? data_wdata : 32'h0, fill, v.e_fill ? fill_paddr : 32'h0};
        exp = {v.e_busy, v.e_req, v.e_req ? v.e_mpaddr : 32'h0, v.e_we,
               v.e_we ? v.e_idx : 5'h0, v.e_we ? v.e_word : 2'h0,
               v.e_we ? v.e_wdata : 32'h0, v.e_fill, v.e_fill ? v.e_fpaddr : 32'h0};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        logic [106:0] act;
        act = {busy, mem_req, mem_paddr, data_we, data_idx, data_word, data_wdata, fill, fill_paddr};
        vectors++;
        if (act !== 107'h0) begin
            miscompares++;
            $display("FAIL %s: outputs %h expected all zero", nm, act);
        end
    endtask

    function automatic vec_t idle_v();
        return mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                   1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0);
    endfunction

    // Minimum-latency refill; optional flush on the second beat must kill the fill.
    task automatic clean_txn(input logic [31:0] pa, input logic clr, input string nm);
        logic [31:0] line, d;
        line = pa & ~32'hF;
        apply_vec(mkv(1'b1, 1'b0, 1'b0, 1'b0, pa, 32'h0, 1'b0, 1'b0, 32'h0,
                      1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0), {nm, "_miss"});
        apply_vec(mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, line,
                      1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0), {nm, "_req"});
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            apply_vec(mkv(1'b0, clr && (b == 1), 1'b0, 1'b1, 32'h0, d, 1'b1, 1'b0, 32'h0,
                          1'b1, idx_of(line), 2'(b), d, 1'b0, 32'h0), {nm, "_beat"});
        end
        apply_vec(mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                      1'b0, 5'h0, 2'h0, 32'h0, !clr, line), {nm, "_fill"});
        apply_vec(idle_v(), {nm, "_idle"});
    endtask

    vec_t tbl [10];

    initial begin
        vec_t v;
        logic [31:0] d;
        logic        m_active, m_acked, m_squash;
        int          m_beats;
        logic [31:0] m_line;

        tbl[0] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0);
        tbl[1] = mkv(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_1230, 1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0);
        tbl[2] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hD0D0_0000, 1'b1, 1'b0, 32'h0, 1'b1, 5'h03, 2'h0, 32'hD0D0_0000, 1'b0, 32'h0);
        tbl[3] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hD1D1_1111, 1'b1, 1'b0, 32'h0, 1'b1, 5'h03, 2'h1, 32'hD1D1_1111, 1'b0, 32'h0);
        tbl[4] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hD2D2_2222, 1'b1, 1'b0, 32'h0, 1'b1, 5'h03, 2'h2, 32'hD2D2_2222, 1'b0, 32'h0);
        tbl[5] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hD3D3_3333, 1'b1, 1'b0, 32'h0, 1'b1, 5'h03, 2'h3, 32'hD3D3_3333, 1'b0, 32'h0);
        tbl[6] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 2'h0, 32'h0, 1'b1, 32'h0000_1230);
        tbl[7] = idle_v();
        tbl[8] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0);
        tbl[9] = idle_v();

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) apply_vec(tbl[i], $sformatf("table%0d", i));

        // Delayed ack, gapped beats, and a miss ignored while busy.
        apply_vec(mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5678, 32'h0, 1'b0, 1'b0, 32'h0,
                      1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0), "slow_miss");
        for (int i = 1; i <= 6; i++)
            apply_vec(mkv(i == 3, 1'b0, i == 6, 1'b0, 32'h0000_2000, 32'h0, 1'b1, 1'b1, 32'h0000_5670,
                          1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0), "slow_req_hold");
        for (int b = 0; b < 4; b++) begin
            d = $urandom;
            apply_vec(mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, d, 1'b1, 1'b0, 32'h0,
                          1'b1, 5'h07, 2'(b), d, 1'b0, 32'h0), "slow_beat");
            if (b < 3)
                apply_vec(mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                              1'b0, 5'h0, 2'h0, 32'h0, 1'b0, 32'h0), "slow_gap");
        end
        apply_vec(mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                      1'b0, 5'h0, 2'h0, 32'h0, 1'b1, 32'h0000_5670), "slow_fill");
        clean_txn(32'h0000_2000, 1'b0, "second_miss");

        clean_txn(32'h0000_3458, 1'b1, "squash");
        clean_txn(32'h0000_3458, 1'b0, "after_squash");

        // Asynchronous reset in the middle of the beat phase.
        apply_vec(tbl[0], "arst_miss");
        apply_vec(tbl[1], "arst_req");
        apply_vec(tbl[2], "arst_beat");
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst_n = 1'b1;
        mem_rvalid = 1'b0;
        clean_txn(32'h0000_1234, 1'b0, "post_reset");

        // Randomized bus with a transaction-level reference.
        m_active = 1'b0; m_acked = 1'b0; m_squash = 1'b0; m_beats = 0; m_line = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v = idle_v();
            v.miss   = ($urandom_range(3, 0) == 0);
            v.clear  = ($urandom_range(19, 0) == 0);
            v.paddr  = $urandom;
            v.rdata  = $urandom;
            v.ack    = m_active && !m_acked && ($urandom_range(2, 0) == 0);
            v.rvalid = (m_active && m_acked && m_beats < 4) ? ($urandom_range(1, 0) == 1)
                                                            : ($urandom_range(5, 0) == 0);
            v.e_busy   = m_active;
            v.e_req    = m_active && !m_acked;
            v.e_mpaddr = m_line;
            v.e_we     = m_active && m_acked && (m_beats < 4) && v.rvalid;
            v.e_idx    = idx_of(m_line);
            v.e_word   = 2'(m_beats);
            v.e_wdata  = v.rdata;
            v.e_fill   = m_active && (m_beats == 4) && !m_squash && !v.clear;
            v.e_fpaddr = m_line;
            apply_vec(v, "random");
            if (!m_active) begin
                if (v.miss && !v.clear) begin
                    m_active = 1'b1; m_acked = 1'b0; m_beats = 0; m_squash = 1'b0;
                    m_line = v.paddr & ~32'hF;
                end
            end else begin
                if (v.clear) m_squash = 1'b1;
                if (!m_acked) begin
                    if (v.ack) m_acked = 1'b1;
                end else if (m_beats < 4) begin
                    if (v.rvalid) m_beats++;
                end else begin
                    m_active = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
